// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit saturating counters,
// trained by the comparator outcome, with registered mispredict flag and stats.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_taken,
  input  logic                resolve_valid,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  input  logic                resolve_pred,
  input  logic                compout,
  output logic                mispredict,
  output logic                actual_taken,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            counters [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] resolve_idx;
  logic [1:0]            cur_ctr;
  logic [1:0]            next_ctr;
  logic                  wrong;

  assign lookup_idx  = lookup_pc[INDEX_BITS+1:2];
  assign resolve_idx = resolve_pc[INDEX_BITS+1:2];
  assign pred_taken  = counters[lookup_idx][1];
  assign cur_ctr     = counters[resolve_idx];
  assign wrong       = compout ^ resolve_pred;

  // Byte-offset and high PC bits are deliberately ignored; aliasing is allowed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            resolve_pc[PC_WIDTH-1:INDEX_BITS+2], resolve_pc[1:0]};

  always_comb begin
    next_ctr = cur_ctr;
    if (compout) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
    end
  end

  // Mispredict detection trusts the carried prediction rather than re-reading the table.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= 2'b01;
      mispredict       <= 1'b0;
      actual_taken     <= 1'b0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      mispredict <= resolve_valid & wrong;
      if (resolve_valid) begin
        counters[resolve_idx] <= next_ctr;
        actual_taken          <= compout;
        branch_count          <= branch_count + 32'd1;
        if (wrong) mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic
// against a table-of-integers reference model.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_pred;
  logic        compout;
  logic        mispredict;
  logic        actual_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .resolve_pred     (resolve_pred),
    .compout          (compout),
    .mispredict       (mispredict),
    .actual_taken     (actual_taken),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mispredict;
    logic        actual_taken;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
  } expect_t;

  expect_t exp_q[$];
  int      errors = 0;
  int      checks = 0;

  int          model_ctr [64];
  logic        model_valid = 1'b0;
  logic        m_actual = 1'b0;
  logic [31:0] m_branches = 0;
  logic [31:0] m_wrong = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  // One cycle: drive at negedge, check the combinational prediction, advance
  // the model and queue the registered response expected after the edge.
  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rpred, input logic cout,
                               input logic [31:0] lpc);
    expect_t e;
    int ri;
    @(negedge clock);
    reset         = rst;
    resolve_valid = rv;
    resolve_pc    = rpc;
    resolve_pred  = rpred;
    compout       = cout;
    lookup_pc     = lpc;
    #1;
    if (model_valid)
      checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, model_ctr[(lpc >> 2) % 64] >= 2});
    if (rst) begin
      foreach (model_ctr[i]) model_ctr[i] = 1;
      model_valid = 1'b1;
      m_actual    = 1'b0;
      m_branches  = 0;
      m_wrong     = 0;
      e.mispredict = 1'b0;
    end else begin
      e.mispredict = rv && (cout != rpred);
      if (rv) begin
        ri = (rpc >> 2) % 64;
        if (cout) model_ctr[ri] = (model_ctr[ri] == 3) ? 3 : model_ctr[ri] + 1;
        else      model_ctr[ri] = (model_ctr[ri] == 0) ? 0 : model_ctr[ri] - 1;
        m_actual   = cout;
        m_branches = m_branches + 1;
        if (cout != rpred) m_wrong = m_wrong + 1;
      end
    end
    e.actual_taken     = m_actual;
    e.branch_count     = m_branches;
    e.mispredict_count = m_wrong;
    if (model_valid) exp_q.push_back(e);
  endtask

  task automatic resolveAt(input logic [31:0] pc, input logic pred, input logic cout);
    applyStimulus(1'b0, 1'b1, pc, pred, cout, pc);
  endtask

  task automatic idle(input logic [31:0] lpc);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lpc);
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("mispredict", {31'd0, mispredict}, {31'd0, e.mispredict});
        checkOutput("actual_taken", {31'd0, actual_taken}, {31'd0, e.actual_taken});
        checkOutput("branch_count", branch_count, e.branch_count);
        checkOutput("mispredict_count", mispredict_count, e.mispredict_count);
      end
    end
  end

  initial begin : driver
    logic [31:0] pcs [6];
    reset = 1'b1; resolve_valid = 1'b0; resolve_pc = 0; resolve_pred = 0;
    compout = 0; lookup_pc = 0;

    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) idle(i * 4);

    resolveAt(32'h40, 1'b0, 1'b1);
    idle(32'h40);
    resolveAt(32'h40, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) resolveAt(32'h40, 1'b1, 1'b1);
    idle(32'h40);
    resolveAt(32'h40, 1'b1, 1'b0);
    idle(32'h40);
    for (int i = 0; i < 2; i++) resolveAt(32'h40, 1'b1, 1'b0);
    idle(32'h40);
    for (int i = 0; i < 4; i++) resolveAt(32'h40, 1'b0, 1'b0);
    idle(32'h40);

    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    resolveAt(32'h40, 1'b0, 1'b1);
    resolveAt(32'h40, 1'b1, 1'b1);
    idle(32'h140);
    idle(32'h44);

    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
    idle(32'h80);

    resolveAt(32'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40);
    idle(32'h40);

    pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h80;
    pcs[3] = 32'h44; pcs[4] = 32'hFFFF_FF03; pcs[5] = 32'h1000_0080;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 5)] : $urandom,
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 5)] : $urandom);
    end

    idle(0);
    repeat (2) @(posedge clock);
    #2;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
